// File: rtl/sigma_pkg.sv
// sigma_pkg: shared state encoding and signed-magnitude <-> two's-complement helpers.
// Rev 1.0
`default_nettype none

package sigma_pkg;

  // Helpers operate on a fixed wide container; callers pass the real width.
  localparam int SM_MAX_W = 64;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } sigma_state_e;

  function automatic logic [SM_MAX_W-1:0] sm_to_tc(input logic [SM_MAX_W-1:0] sm, input int w);
    logic [SM_MAX_W-1:0] mag;
    logic                neg;
    mag = sm & ((SM_MAX_W'(1) << (w - 1)) - SM_MAX_W'(1));
    neg = ((sm >> (w - 1)) & SM_MAX_W'(1)) != '0;
    return neg ? -mag : mag;
  endfunction

  // Returns {sat, sign-magnitude word}; zero is always emitted as positive zero.
  function automatic logic [SM_MAX_W:0] tc_to_sm_sat(input logic [SM_MAX_W-1:0] s, input int w);
    logic                neg;
    logic [SM_MAX_W-1:0] absv;
    logic [SM_MAX_W-1:0] maxmag;
    logic [SM_MAX_W-1:0] sgnbit;
    neg    = s[SM_MAX_W-1];
    absv   = neg ? -s : s;
    maxmag = (SM_MAX_W'(1) << (w - 1)) - SM_MAX_W'(1);
    sgnbit = neg ? (SM_MAX_W'(1) << (w - 1)) : '0;
    if (absv > maxmag) begin
      return {1'b1, sgnbit | maxmag};
    end else if (absv == '0) begin
      return '0;
    end
    return {1'b0, sgnbit | absv};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sm_lane_sum.sv
// sm_lane_sum: combinational sum of LANES signed-magnitude words into an ACC_W two's-complement value.
// Rev 1.0
`default_nettype none

module sm_lane_sum
  import sigma_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int ACC_W = 37
) (
  input  logic [LANES-1:0][WIDTH-1:0] lanes,
  output logic [ACC_W-1:0]            sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + ACC_W'(sm_to_tc(SM_MAX_W'(lanes[i]), WIDTH));
    end
  end

endmodule

`default_nettype wire

// File: rtl/sigma_stream.sv
// sigma_stream: multi-beat signed-magnitude accumulator with saturated signed-magnitude result.
// Rev 1.0
`default_nettype none

module sigma_stream
  import sigma_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 17,
  parameter int LANES = 4,
  parameter int TERMS = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES-1:0][WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_sat
);

  localparam int BEATS = TERMS / LANES;
  localparam int ACC_W = WIDTH + $clog2(TERMS);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (LANES < 1 || (TERMS % LANES) != 0 || FRAC >= WIDTH || ACC_W > SM_MAX_W) begin : g_param_check
    $error("sigma_stream: illegal parameter combination");
  end

  sigma_state_e     r_state;
  sigma_state_e     w_next_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [ACC_W-1:0] w_beat_sum;
  logic [ACC_W-1:0] w_total;
  logic [SM_MAX_W:0] w_result;
  logic [WIDTH-1:0] w_result_sm;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_sat;

  sm_lane_sum #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .ACC_W (ACC_W)
  ) u_lane_sum (
    .lanes (in_data),
    .sum   (w_beat_sum)
  );

  assign w_accept    = in_valid && in_ready;
  assign w_last      = (r_beat_cnt == CNT_W'(BEATS - 1));
  assign w_total     = r_acc + w_beat_sum;
  assign w_result    = tc_to_sm_sat(SM_MAX_W'(signed'(w_total)), WIDTH);
  assign w_result_sm = WIDTH'(w_result);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_next_state;
    end
  end

  // in_ready depends only on registered state (and reset), never on out_ready.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready = !rst;
        if (w_accept && w_last) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = ACCUM;
        end
      end
      default: w_next_state = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_beat_cnt <= '0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        r_acc      <= '0;
        r_beat_cnt <= '0;
        r_out_data <= w_result_sm;
        r_out_sat  <= w_result[SM_MAX_W];
      end else begin
        r_acc      <= w_total;
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  assign out_data = r_out_data;
  assign out_sat  = r_out_sat;

endmodule

`default_nettype wire

// File: tb/tb_sigma_stream.sv
// tb_sigma_stream: directed self-checking bench for sigma_stream (4-lane and 32-lane builds).
// Rev 1.0
`default_nettype none

module tb_sigma_stream;

  localparam logic [31:0] PI  = 32'h0006487e;
  localparam logic [31:0] NPI = 32'h8006487e;
  localparam logic [31:0] ONE = 32'h00020000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0][31:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic             out_sat;

  logic              v2 = 1'b0;
  logic              rdy2;
  logic [31:0][31:0] d2 = '0;
  logic              ov2;
  logic              or2 = 1'b0;
  logic [31:0]       od2;
  logic              os2;

  logic [31:0] ops [32];
  int n_cmp  = 0;
  int n_fail = 0;

  sigma_stream #(.WIDTH(32), .FRAC(17), .LANES(4), .TERMS(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  sigma_stream #(.WIDTH(32), .FRAC(17), .LANES(32), .TERMS(32)) dut_wide (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_sat(os2)
  );

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < 32; i++) ops[i] = v;
  endtask

  // Offer beats 0..beats-1 from ops[], with optional idle gaps; returns #1 after the last accepting edge.
  task automatic feed(input int beats, input int gap_max);
    for (int b = 0; b < beats; b++) begin
      int t;
      if (gap_max > 0) begin
        int g;
        in_valid = 1'b0;
        g = $urandom_range(0, gap_max);
        repeat (g) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      for (int l = 0; l < 4; l++) in_data[l] = ops[b*4 + l];
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready) begin @(posedge clk); #1; break; end
        t++;
        if (t > 50) begin
          n_cmp++; n_fail++;
          $display("FAIL accept_timeout beat=%0d in_ready=%b required 1", b, in_ready);
          break;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic take_result(output logic [31:0] d, output logic s);
    int t = 0;
    while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
    if (!out_valid) begin
      n_cmp++; n_fail++;
      $display("FAIL result_timeout out_valid=%b required 1", out_valid);
    end
    d = out_data;
    s = out_sat;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_data !== 32'h0 || out_sat !== 1'b0) begin
      n_fail++; $display("FAIL rst_out got=%h/%b exp=00000000/0", out_data, out_sat);
    end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_pi();
    logic [31:0] d; logic s;
    fill(PI);
    feed(7, 0);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pi_early_valid got=%b exp=0", out_valid); end
    feed(1, 0);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pi_latency got=%b exp=1", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL pi_done_ready got=%b exp=0", in_ready); end
    take_result(d, s);
    n_cmp++; if (d !== 32'h00C90FC0 || s !== 1'b0) begin
      n_fail++; $display("FAIL pi_sum got=%h/%b exp=00c90fc0/0", d, s);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pi_consumed got=%b exp=0", out_valid); end
  endtask

  task automatic test_cancel();
    logic [31:0] d; logic s;
    for (int i = 0; i < 32; i++) ops[i] = (i % 2 == 0) ? PI : NPI;
    feed(8, 0); take_result(d, s);
    n_cmp++; if (d !== 32'h0 || s !== 1'b0) begin n_fail++; $display("FAIL cancel got=%h/%b exp=00000000/0", d, s); end
    fill(32'h80000000);
    feed(8, 0); take_result(d, s);
    n_cmp++; if (d !== 32'h0 || s !== 1'b0) begin n_fail++; $display("FAIL neg_zero got=%h/%b exp=00000000/0", d, s); end
    fill(NPI);
    feed(8, 0); take_result(d, s);
    n_cmp++; if (d !== 32'h80C90FC0 || s !== 1'b0) begin n_fail++; $display("FAIL neg_pi got=%h/%b exp=80c90fc0/0", d, s); end
  endtask

  task automatic test_saturate();
    logic [31:0] d; logic s;
    fill(32'h7FFFFFFF);
    feed(8, 0); take_result(d, s);
    n_cmp++; if (d !== 32'h7FFFFFFF || s !== 1'b1) begin n_fail++; $display("FAIL sat_pos got=%h/%b exp=7fffffff/1", d, s); end
    fill(32'hFFFFFFFF);
    feed(8, 0); take_result(d, s);
    n_cmp++; if (d !== 32'hFFFFFFFF || s !== 1'b1) begin n_fail++; $display("FAIL sat_neg got=%h/%b exp=ffffffff/1", d, s); end
    fill(32'h0); ops[0] = 32'h7FFFFFFF;
    feed(8, 0); take_result(d, s);
    n_cmp++; if (d !== 32'h7FFFFFFF || s !== 1'b0) begin n_fail++; $display("FAIL max_exact got=%h/%b exp=7fffffff/0", d, s); end
    ops[1] = 32'h00000001;
    feed(8, 0); take_result(d, s);
    n_cmp++; if (d !== 32'h7FFFFFFF || s !== 1'b1) begin n_fail++; $display("FAIL max_plus1 got=%h/%b exp=7fffffff/1", d, s); end
    fill(32'h0); ops[29] = 32'hFFFFFFFF;
    feed(8, 0); take_result(d, s);
    n_cmp++; if (d !== 32'hFFFFFFFF || s !== 1'b0) begin n_fail++; $display("FAIL min_exact got=%h/%b exp=ffffffff/0", d, s); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic s;
    fill(PI);
    feed(8, 0);
    fill(ONE);
    in_valid = 1'b1;
    for (int l = 0; l < 4; l++) in_data[l] = ONE;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h00C90FC0) begin
        n_fail++; $display("FAIL bp_hold cyc=%0d got rdy=%b vld=%b data=%h exp 0/1/00c90fc0", c, in_ready, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release got rdy=%b vld=%b exp 1/0", in_ready, out_valid);
    end
    feed(8, 0); take_result(d, s);
    n_cmp++; if (d !== 32'h00400000 || s !== 1'b0) begin n_fail++; $display("FAIL bp_next got=%h/%b exp=00400000/0", d, s); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic s;
    fill(PI);
    feed(3, 0);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    fill(ONE);
    feed(8, 0); take_result(d, s);
    n_cmp++; if (d !== 32'h00400000 || s !== 1'b0) begin n_fail++; $display("FAIL rst_partial got=%h/%b exp=00400000/0", d, s); end
    fill(PI);
    feed(8, 0);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      n_fail++; $display("FAIL rst_done got vld=%b data=%h exp 0/00000000", out_valid, out_data);
    end
  endtask

  task automatic test_gaps();
    logic [31:0] d; logic s;
    for (int i = 0; i < 32; i++) ops[i] = (i % 2 == 1) ? (32'h80000000 | (i * 32'h100)) : (i * 32'h100);
    feed(8, 0); take_result(d, s);
    n_cmp++; if (d !== 32'h80001000 || s !== 1'b0) begin n_fail++; $display("FAIL alt_nogap got=%h/%b exp=80001000/0", d, s); end
    feed(8, 3); take_result(d, s);
    n_cmp++; if (d !== 32'h80001000 || s !== 1'b0) begin n_fail++; $display("FAIL alt_gaps got=%h/%b exp=80001000/0", d, s); end
  endtask

  task automatic test_single_beat();
    for (int rep = 0; rep < 2; rep++) begin
      int t = 0;
      repeat (rep * 3) begin @(posedge clk); #1; end
      for (int l = 0; l < 32; l++) d2[l] = PI;
      v2 = 1'b1;
      while (t < 50) begin
        @(negedge clk);
        if (rdy2) break;
        t++;
      end
      n_cmp++; if (rdy2 !== 1'b1) begin n_fail++; $display("FAIL wide_ready rep=%0d got=%b exp=1", rep, rdy2); end
      @(posedge clk); #1;
      v2 = 1'b0;
      n_cmp++; if (ov2 !== 1'b1 || od2 !== 32'h00C90FC0 || os2 !== 1'b0) begin
        n_fail++; $display("FAIL wide_sum rep=%0d got vld=%b %h/%b exp 1 00c90fc0/0", rep, ov2, od2, os2);
      end
      or2 = 1'b1; @(posedge clk); #1; or2 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_pi();
    test_cancel();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    test_gaps();
    test_single_beat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
